out_requant: RTL and testbench
==============================

Name: out_requant

Overview:
- Downstream stage of the matmul tile controller.
- Consumes the 16 accumulator rows of a finished tile. Each row is 16 lanes of signed 24-bit partial sums.
- Requantizes each lane to INT8 using round-half-up arithmetic shift and saturation.
- Buffers rows in a small FIFO and writes them to the output buffer with a valid/ready handshake and row addresses.

Parameters:
- LANES, 16, lanes per accumulator row
- AW, 24, accumulator lane width (signed)
- OW, 8, output lane width (signed)
- ROWS, 16, rows per tile
- DEPTH, 4, output FIFO depth (power of 2)
- ADDR_W, 14, output buffer address width

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_start  in  1  tile start pulse; latches i_shift, i_base_addr and i_relu; clears o_overflow
- i_shift  in  5  right-shift amount, 0..23
- i_relu  in  1  ReLU enable; ignored unless OUT_RELU_EN is defined
- i_base_addr  in  ADDR_W  output address of row 0
- i_valid  in  1  accumulator row valid; no backpressure toward the producer
- i_data  in  LANES*AW  accumulator row; lane g at [g*AW +: AW]
- o_valid  out  1  output row valid
- i_ready  in  1  output buffer accepts the row
- o_data  out  LANES*OW  requantized row; lane g at [g*OW +: OW]
- o_addr  out  ADDR_W  output buffer address
- o_last  out  1  marks row ROWS-1 of the tile
- o_done  out  1  one-cycle pulse after the last row handshake
- o_overflow  out  1  sticky flag: a row was dropped
- o_busy  out  1  high in S_RUN

Behaviour:
- Reset (synchronous, i_rst_n=0 at a rising edge): all outputs 0, FIFO empty, pipeline register invalid, row counters 0, state S_IDLE. Reset mid-tile discards all buffered rows.
- Clock and reset: single clock i_clk; reset is synchronous and active-low on i_rst_n.
- State machine:
  - S_IDLE: i_start moves to S_RUN and latches the configuration. i_valid is ignored in this state.
  - S_RUN: i_start is ignored. When the handshake (o_valid && i_ready) completes with o_last=1, the block moves to S_IDLE and pulses o_done the next cycle.
- Requant, per lane, on signed x:
  - Shift 0: y=x.
  - Otherwise: y=(x + (1<<(s-1))) >>> s. The add is done at AW+1 bits so it cannot overflow.
  - Saturate y to [-128,127].
  - Shift values above 23 are treated as 23.
- Stage 1: register the requantized row plus a valid bit. Captured only in S_RUN while in_cnt<ROWS. in_cnt counts accepted rows; rows beyond ROWS are ignored.
- Stage 2: FIFO of DEPTH entries.
  - Written when stage 1 is valid and the FIFO is not full, or when it is full and popped in the same cycle.
  - If stage 1 is valid while the FIFO is full and no pop occurs, the row is dropped, o_overflow is set, and the address counter still advances.
  - Simultaneous push and pop on a full or empty FIFO is legal and keeps the count consistent.
- Outputs:
  - o_valid = FIFO not empty; o_data is the FIFO head (show-ahead).
  - o_addr = base + out_cnt.
  - o_last = (out_cnt == ROWS-1).
  - out_cnt advances on each handshake and wraps to 0 after the last row.
- Latency: i_valid at cycle t gives o_valid at t+2 when the FIFO is empty.
- o_valid holds and o_data stays stable until i_ready.

Optional Feature:
- OUT_RELU_EN:
  - Defined: when the latched i_relu=1, negative saturated lanes output 0. This adds no cycles.
  - Undefined: i_relu is unused and the output is plain signed saturation.

Decomposition:
- Shared package holds:
  - Lane width constants (AW, OW).
  - Saturation bounds: OUT_MAX=127, OUT_MIN=-128.
  - State encodings S_IDLE and S_RUN.
  - ROWS_PER_TILE=16.
- One sub-module is natural: sync_fifo (parameterised width and depth, show-ahead, full/empty/count). It is reusable for the input buffer loaders.
- Requant is a per-lane generate loop, not a separate module.

Test Plan:
- Basic tile: shift=4, base=0x100, i_ready=1.
  - Input: 16 rows, lane0=0x000018 (24), lane1=0xFFFFE8 (-24), other lanes 0x0007F0.
  - Expect: lane0=2, lane1=-1, others=127; o_addr runs 0x100..0x10F; o_last on 0x10F; o_done one cycle later.
- Saturation and rounding: shift=0 with input 0x7FFFFF → 127 and 0x800000 → -128. Shift=1 with input 3 → 2 and input -3 → -1.
- Backpressure: i_ready=0 for 6 cycles during a 16-row burst.
  - Expect: o_overflow=1; the rows after FIFO full are lost; received addresses skip the dropped rows; no X on outputs.
  - Repeat with i_ready stalls of 2 cycles: o_overflow=0 and all 16 rows arrive in order.
- ReLU (macro defined, i_relu=1, shift=2): input -40 → 0 and 40 → 10. With the macro undefined: -40 → -10.
- Reset mid-tile: assert i_rst_n=0 after 5 rows.
  - Expect: o_valid=0, o_busy=0, o_overflow=0 next cycle.
  - A new i_start then completes a full tile with o_addr starting at the new base.

Source files
------------

// File: rtl/out_requant_pkg.sv
// Shared definitions for the output requantization stage.
// Holds lane widths, saturation bounds, tile geometry and FSM state encodings.
// Build option: define OUT_RELU_EN to enable the ReLU clamp in out_requant.
package out_requant_pkg;

  localparam int AW            = 24;   // accumulator lane width (signed)
  localparam int OW            = 8;    // output lane width (signed)
  localparam int LANES         = 16;   // lanes per row
  localparam int ROWS_PER_TILE = 16;   // rows per tile
  localparam int DEPTH         = 4;    // output FIFO depth
  localparam int ADDR_W        = 14;   // output buffer address width
  localparam int SHIFT_MAX     = 23;   // larger shift requests are clamped here

  localparam int OUT_MAX = 127;
  localparam int OUT_MIN = -128;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/out_requant_sync_fifo.sv
// Synchronous show-ahead FIFO with full/empty/count.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset (empties the FIFO)
//   i_wr, i_wdata  : write request and data; a write while full is accepted
//                    only when a read happens in the same cycle
//   i_rd           : read request; ignored while empty
//   o_rdata        : current head entry (valid whenever o_empty is low)
//   o_full, o_empty, o_count : occupancy status
// DEPTH must be a power of two (pointers wrap naturally).
module out_requant_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_rd,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_wr;
  logic             do_rd;

  assign o_full  = (count == FULL_CNT);
  assign o_empty = (count == '0);
  assign o_count = count;
  assign o_rdata = mem[rd_ptr];

  // A write into a full FIFO lands in the slot being read out this cycle.
  assign do_wr = i_wr && (!o_full || i_rd);
  assign do_rd = i_rd && !o_empty;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= i_wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/out_requant.sv
// Output requantization stage of the matmul tile controller.
// Takes ROWS accumulator rows (LANES x signed AW-bit) per tile, requantizes
// every lane to signed OW bits (round-half-up arithmetic shift, saturation),
// registers the row, buffers it in a DEPTH-entry FIFO and writes it to the
// output buffer with a valid/ready handshake and a row address.
// Build option: OUT_RELU_EN -- when defined, a latched i_relu=1 forces
// negative saturated lanes to 0; when undefined i_relu is ignored.
// Ports:
//   i_clk, i_rst_n   : clock, synchronous active-low reset
//   i_start          : tile start (S_IDLE only); latches shift/base/relu,
//                      clears o_overflow
//   i_shift, i_relu, i_base_addr : tile configuration
//   i_valid, i_data  : accumulator row input, no backpressure
//   o_valid, i_ready, o_data, o_addr, o_last : output row handshake
//   o_done           : one-cycle pulse after the last row handshake
//   o_overflow       : sticky, a row was dropped because the FIFO was full
//   o_busy           : high in S_RUN
//   o_state          : FSM state for debug
// Handshake: a row transfers on a rising edge where o_valid && i_ready;
// while o_valid is high and i_ready low, o_data/o_addr/o_last hold steady.
module out_requant #(
  parameter int LANES  = out_requant_pkg::LANES,
  parameter int AW     = out_requant_pkg::AW,
  parameter int OW     = out_requant_pkg::OW,
  parameter int ROWS   = out_requant_pkg::ROWS_PER_TILE,
  parameter int DEPTH  = out_requant_pkg::DEPTH,
  parameter int ADDR_W = out_requant_pkg::ADDR_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [4:0]            i_shift,
  input  logic                  i_relu,
  input  logic [ADDR_W-1:0]     i_base_addr,
  input  logic                  i_valid,
  input  logic [LANES*AW-1:0]   i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [LANES*OW-1:0]   o_data,
  output logic [ADDR_W-1:0]     o_addr,
  output logic                  o_last,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic                  o_busy,
  output logic [0:0]            o_state
);
  import out_requant_pkg::*;

  localparam int IDX_W   = $clog2(ROWS);
  localparam int ROW_W   = LANES*OW;
  localparam int ENTRY_W = ROW_W + IDX_W;

  localparam logic [IDX_W:0]   ROWS_C    = (IDX_W+1)'(ROWS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ROWS-1);
  localparam logic [4:0]       SHIFT_CAP = 5'(SHIFT_MAX);
  localparam logic signed [AW:0] SAT_HI  = (AW+1)'(OUT_MAX);
  localparam logic signed [AW:0] SAT_LO  = (AW+1)'(OUT_MIN);

  state_t              state;
  logic [4:0]          shift_q;
  logic [ADDR_W-1:0]   base_q;
  logic [IDX_W:0]      in_cnt;
  logic                s1_valid;
  logic [ROW_W-1:0]    s1_data;
  logic [IDX_W-1:0]    s1_idx;
  logic                overflow_q;
  logic                done_q;
`ifdef OUT_RELU_EN
  logic                relu_q;
`else
  logic                unused_relu;
  assign unused_relu = i_relu;
`endif

  // ---------------------------------------------------------------
  // Per-lane requantization (combinational, registered into stage 1)
  // ---------------------------------------------------------------
  logic [ROW_W-1:0] req_row;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [AW-1:0] x;
    logic signed [AW:0]   xe;
    logic signed [AW:0]   rnd;
    logic signed [AW:0]   sum;
    logic signed [AW:0]   shr;
    logic [OW-1:0]        y;

    assign x   = i_data[g*AW +: AW];
    assign xe  = {x[AW-1], x};
    // Rounding constant is zero for shift 0, so the shift path covers y=x.
    assign rnd = (shift_q == 5'd0) ? '0 : ((AW+1)'(1) << (shift_q - 5'd1));
    assign sum = xe + rnd;
    assign shr = sum >>> shift_q;

    always_comb begin
      if (shr > SAT_HI) begin
        y = SAT_HI[OW-1:0];
      end else if (shr < SAT_LO) begin
        y = SAT_LO[OW-1:0];
      end else begin
        y = shr[OW-1:0];
      end
`ifdef OUT_RELU_EN
      if (relu_q && y[OW-1]) begin
        y = '0;
      end
`endif
    end

    assign req_row[g*OW +: OW] = y;
  end

  // ---------------------------------------------------------------
  // Output FIFO: each entry carries the row index so that addresses of
  // surviving rows stay correct when a row is dropped on overflow.
  // ---------------------------------------------------------------
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [ENTRY_W-1:0]     head;
  logic [$clog2(DEPTH):0] fifo_count_unused;
  logic                   push;
  logic                   pop;
  logic                   drop;
  logic [ROW_W-1:0]       head_data;
  logic [IDX_W-1:0]       head_idx;
  logic [ADDR_W-1:0]      row_off;

  assign pop  = !fifo_empty && i_ready;
  assign push = s1_valid && (!fifo_full || pop);
  assign drop = s1_valid && fifo_full && !pop;

  out_requant_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wr    (push),
    .i_wdata ({s1_idx, s1_data}),
    .i_rd    (pop),
    .o_rdata (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count_unused)
  );

  assign head_data = head[ROW_W-1:0];
  assign head_idx  = head[ENTRY_W-1:ROW_W];

  // Outputs are masked while empty so stale/uninitialised FIFO slots never
  // reach the output buffer interface.
  assign row_off    = fifo_empty ? '0 : ADDR_W'(head_idx);
  assign o_valid    = !fifo_empty;
  assign o_data     = fifo_empty ? '0 : head_data;
  assign o_addr     = base_q + row_off;
  assign o_last     = !fifo_empty && (head_idx == LAST_IDX);
  assign o_done     = done_q;
  assign o_overflow = overflow_q;
  assign o_busy     = (state == S_RUN);
  assign o_state    = state;

  // ---------------------------------------------------------------
  // Control FSM with stage-1 register, row counter and status flags
  // ---------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      shift_q    <= '0;
      base_q     <= '0;
      in_cnt     <= '0;
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s1_idx     <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef OUT_RELU_EN
      relu_q     <= 1'b0;
`endif
    end else begin
      done_q   <= 1'b0;
      s1_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state      <= S_RUN;
            shift_q    <= (i_shift > SHIFT_CAP) ? SHIFT_CAP : i_shift;
            base_q     <= i_base_addr;
            in_cnt     <= '0;
            overflow_q <= 1'b0;
`ifdef OUT_RELU_EN
            relu_q     <= i_relu;
`endif
          end
        end
        S_RUN: begin
          // Rows past the end of the tile are ignored.
          if (i_valid && (in_cnt < ROWS_C)) begin
            s1_valid <= 1'b1;
            s1_data  <= req_row;
            s1_idx   <= in_cnt[IDX_W-1:0];
            in_cnt   <= in_cnt + 1'b1;
          end
          if (drop) begin
            overflow_q <= 1'b1;
          end
          if (pop && o_last) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_requant.sv
// Testbench for out_requant: directed tile scenarios with randomized lane
// data, checked against an arithmetic reference model of the requant rules.
module tb_out_requant;

  localparam int LANES  = 16;
  localparam int AW     = 24;
  localparam int OW     = 8;
  localparam int ADDR_W = 14;
  localparam int ROWS   = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                  i_start;
  logic [4:0]            i_shift;
  logic                  i_relu;
  logic [ADDR_W-1:0]     i_base_addr;
  logic                  i_valid;
  logic [LANES*AW-1:0]   i_data;
  logic                  o_valid;
  logic                  i_ready;
  logic [LANES*OW-1:0]   o_data;
  logic [ADDR_W-1:0]     o_addr;
  logic                  o_last;
  logic                  o_done;
  logic                  o_overflow;
  logic                  o_busy;
  logic [0:0]            o_state;

  out_requant dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (i_start),
    .i_shift     (i_shift),
    .i_relu      (i_relu),
    .i_base_addr (i_base_addr),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_addr      (o_addr),
    .o_last      (o_last),
    .o_done      (o_done),
    .o_overflow  (o_overflow),
    .o_busy      (o_busy),
    .o_state     (o_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  logic [LANES*AW-1:0] rows [32];
  logic [LANES*OW-1:0] exp_q [$];
  logic [LANES*OW-1:0] got_data [$];
  logic [ADDR_W-1:0]   got_addr [$];
  logic                got_last [$];

  int cyc_n       = 0;
  int done_cnt    = 0;
  int last_hs_cyc = -10;
  int done_cyc    = -20;
  int hold_err    = 0;
  bit x_chk       = 1'b0;
  bit x_seen      = 1'b0;
  bit prev_stall  = 1'b0;
  logic [LANES*OW-1:0] prev_data;
  logic [ADDR_W-1:0]   prev_addr;

  always @(posedge clk) cyc_n++;

  // Output monitor: records handshakes, done pulses, hold violations, X.
  always @(negedge clk) begin
    if (x_chk && $isunknown({o_valid, o_data, o_addr, o_last, o_done, o_overflow, o_busy}))
      x_seen = 1'b1;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!o_valid || o_data !== prev_data || o_addr !== prev_addr))
        hold_err++;
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
      prev_addr  = o_addr;
      if (o_valid && i_ready) begin
        got_data.push_back(o_data);
        got_addr.push_back(o_addr);
        got_last.push_back(o_last);
        if (o_last) last_hs_cyc = cyc_n;
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc_n;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [OW-1:0] ref_lane(input logic [AW-1:0] raw, input int s, input bit relu);
    longint x, v, d, q;
    int sc;
    bit relu_on;
    x  = longint'($signed(raw));
    sc = (s > 23) ? 23 : s;
    if (sc == 0) begin
      q = x;
    end else begin
      d = longint'(1) << sc;
      v = x + d / 2;
      q = v / d;
      if ((v % d) != 0 && v < 0) q = q - 1;   // floor division
    end
    if (q > 127) q = 127;
    else if (q < -128) q = -128;
    relu_on = relu;
`ifndef OUT_RELU_EN
    relu_on = 1'b0;
`endif
    if (relu_on && q < 0) q = 0;
    return 8'(q);
  endfunction

  function automatic logic [LANES*OW-1:0] model_row(input logic [LANES*AW-1:0] r, input int s, input bit relu);
    logic [LANES*OW-1:0] out;
    out = '0;
    for (int g = 0; g < LANES; g++) out[g*OW +: OW] = ref_lane(r[g*AW +: AW], s, relu);
    return out;
  endfunction

  function automatic logic [AW-1:0] rand_lane();
    int r;
    r = int'($urandom());
    r = r >>> $urandom_range(8, 31);
    return 24'(r);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic fill_rows();
    for (int r = 0; r < 32; r++)
      for (int g = 0; g < LANES; g++) rows[r][g*AW +: AW] = rand_lane();
  endtask

  task automatic start_tile(input logic [4:0] sh, input logic [ADDR_W-1:0] base, input bit relu);
    i_shift = sh; i_base_addr = base; i_relu = relu; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    got_data.delete(); got_addr.delete(); got_last.delete();
    check("start_busy", o_busy, 1'b1);
  endtask

  // Drives n_send rows (one every 'every' cycles) with i_ready from a
  // rotating pattern and an optional stall window, until o_done is seen.
  // Also pulses i_start with junk configuration mid-tile.
  task automatic drive_tile(input int n_send, input int every, input logic [7:0] pat,
                            input int st_lo, input int st_hi);
    int sent;
    int cyc;
    int d0;
    sent = 0; cyc = 0; d0 = done_cnt;
    while ((sent < n_send || done_cnt == d0) && cyc < 300) begin
      i_valid = (sent < n_send) && (cyc % every == 0);
      if (i_valid) begin
        i_data = rows[sent];
        sent++;
      end
      i_ready = pat[cyc % 8] && !(cyc >= st_lo && cyc < st_hi);
      i_start = (cyc == 3);
      if (cyc == 3) begin
        i_base_addr = 14'($urandom());
        i_shift     = 5'($urandom());
      end
      @(posedge clk); #1;
      cyc++;
    end
    i_valid = 1'b0; i_start = 1'b0; i_ready = 1'b1;
    check("tile_finished", done_cnt != d0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Full-tile comparison: all ROWS rows in order, addresses, last, done.
  task automatic check_tile(input string tag, input logic [ADDR_W-1:0] base, input int sh, input bit relu);
    exp_q.delete();
    for (int r = 0; r < ROWS; r++) exp_q.push_back(model_row(rows[r], sh, relu));
    check({tag, "_count"}, got_data.size(), ROWS);
    for (int r = 0; r < ROWS; r++) begin
      if (r < got_data.size()) begin
        check($sformatf("%s_row%0d_data", tag, r), got_data[r], exp_q[r]);
        check($sformatf("%s_row%0d_addr", tag, r), got_addr[r], 14'(base + r));
        check($sformatf("%s_row%0d_last", tag, r), got_last[r], (r == ROWS-1));
      end
    end
    check({tag, "_done_timing"}, done_cyc - last_hs_cyc, 1);
    check({tag, "_idle"}, o_busy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [ADDR_W-1:0] base;
    int sh;
    bit relu;
    int prev_idx;
    int idx;

    rst_n = 1'b0; i_start = 1'b0; i_shift = '0; i_relu = 1'b0; i_base_addr = '0;
    i_valid = 1'b0; i_data = '0; i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_overflow", o_overflow, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_addr", o_addr, 14'h0);
    check("rst_data", o_data, 128'h0);
    check("rst_last", o_last, 1'b0);
    rst_n = 1'b1;
    x_chk = 1'b1;

    // Basic tile; rows presented in S_IDLE beforehand must be ignored.
    for (int r = 0; r < ROWS; r++)
      for (int g = 0; g < LANES; g++)
        rows[r][g*AW +: AW] = (g == 0) ? 24'h000018 : (g == 1) ? 24'hFFFFE8 : 24'h0007F0;
    i_valid = 1'b1; i_data = rows[0];
    repeat (3) @(posedge clk);
    #1;
    i_valid = 1'b0;
    check("idle_no_output", o_valid, 1'b0);
    start_tile(5'd4, 14'h100, 1'b0);
    drive_tile(ROWS, 1, 8'hFF, 0, 0);
    check_tile("basic", 14'h100, 4, 1'b0);
    check("basic_lane0", got_data[0][7:0], 8'd2);
    check("basic_lane1", got_data[0][15:8], 8'hFF);
    check("basic_lane2", got_data[0][23:16], 8'd127);
    check("basic_last_addr", got_addr[ROWS-1], 14'h10F);

    // Saturation at shift 0.
    fill_rows();
    for (int r = 0; r < ROWS; r++) begin
      rows[r][0 +: AW]  = 24'h7FFFFF;
      rows[r][AW +: AW] = 24'h800000;
    end
    base = 14'($urandom());
    start_tile(5'd0, base, 1'b0);
    drive_tile(ROWS, 1, 8'hFF, 0, 0);
    check_tile("sat", base, 0, 1'b0);
    check("sat_pos", got_data[0][7:0], 8'h7F);
    check("sat_neg", got_data[0][15:8], 8'h80);

    // Rounding at shift 1.
    fill_rows();
    for (int r = 0; r < ROWS; r++) begin
      rows[r][0 +: AW]  = 24'h000003;
      rows[r][AW +: AW] = 24'hFFFFFD;
    end
    base = 14'($urandom());
    start_tile(5'd1, base, 1'b0);
    drive_tile(ROWS, 1, 8'hFF, 0, 0);
    check_tile("round", base, 1, 1'b0);
    check("round_pos", got_data[0][7:0], 8'd2);
    check("round_neg", got_data[0][15:8], 8'hFF);

    // ReLU request at shift 2.
    fill_rows();
    for (int r = 0; r < ROWS; r++) begin
      rows[r][0 +: AW]  = 24'hFFFFD8;
      rows[r][AW +: AW] = 24'h000028;
    end
    base = 14'($urandom());
    start_tile(5'd2, base, 1'b1);
    drive_tile(ROWS, 1, 8'hFF, 0, 0);
    check_tile("relu", base, 2, 1'b1);
`ifdef OUT_RELU_EN
    check("relu_neg", got_data[0][7:0], 8'd0);
`else
    check("relu_neg", got_data[0][7:0], 8'hF6);
`endif
    check("relu_pos", got_data[0][15:8], 8'd10);

    // Random tiles: random shift (including values above 23), extra rows.
    for (int t = 0; t < 3; t++) begin
      fill_rows();
      base = 14'($urandom());
      sh   = $urandom_range(0, 31);
      relu = 1'($urandom());
      start_tile(5'(sh), base, relu);
      drive_tile(ROWS + 2, 1, 8'hFF, 0, 0);
      check_tile($sformatf("rand%0d", t), base, sh, relu);
    end

    // Two-cycle ready stalls with sparse input: nothing may be lost.
    fill_rows();
    base = 14'($urandom());
    start_tile(5'd6, base, 1'b0);
    drive_tile(ROWS, 2, 8'b1100_1100, 0, 0);
    check_tile("stall2", base, 6, 1'b0);
    check("stall2_overflow", o_overflow, 1'b0);
    check("stall2_hold", hold_err, 0);

    // Six-cycle stall during a back-to-back burst: rows 5..7 are dropped.
    fill_rows();
    base = 14'h2F8;
    start_tile(5'd5, base, 1'b0);
    drive_tile(ROWS, 1, 8'hFF, 3, 9);
    check("drop_overflow", o_overflow, 1'b1);
    check("drop_count", got_data.size(), 13);
    prev_idx = -1;
    for (int k = 0; k < got_data.size(); k++) begin
      idx = int'(14'(got_addr[k] - base));
      check($sformatf("drop_order%0d", k), idx > prev_idx && idx < ROWS, 1'b1);
      if (idx < ROWS) begin
        check($sformatf("drop_data%0d", k), got_data[k], model_row(rows[idx], 5, 1'b0));
        check($sformatf("drop_last%0d", k), got_last[k], (idx == ROWS-1));
      end
      prev_idx = idx;
    end
    check("drop_lost_row5", got_addr.size() > 5 ? got_addr[5] : 14'h0, 14'(base + 8));
    check("drop_hold", hold_err, 0);

    // Reset in the middle of a tile, with first-row latency check.
    fill_rows();
    i_ready = 1'b0;
    start_tile(5'd3, 14'h0A0, 1'b0);
    for (int r = 0; r < 5; r++) begin
      i_valid = 1'b1; i_data = rows[r];
      @(posedge clk); #1;
      if (r == 0) check("lat_t1_valid", o_valid, 1'b0);
      if (r == 1) begin
        check("lat_t2_valid", o_valid, 1'b1);
        check("lat_t2_data", o_data, model_row(rows[0], 3, 1'b0));
        check("lat_t2_addr", o_addr, 14'h0A0);
      end
    end
    i_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_overflow", o_overflow, 1'b1);
    check("mid_busy", o_busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_valid", o_valid, 1'b0);
    check("midrst_busy", o_busy, 1'b0);
    check("midrst_overflow", o_overflow, 1'b0);
    rst_n = 1'b1; i_ready = 1'b1;
    @(posedge clk); #1;
    fill_rows();
    base = 14'h3A0;
    start_tile(5'd7, base, 1'b0);
    drive_tile(ROWS, 1, 8'hFF, 0, 0);
    check_tile("after_rst", base, 7, 1'b0);

    check("no_x", x_seen, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
